shabal_host_if: RTL and testbench
=================================

Name: shabal_host_if

Overview:
- Device-side responder for the 16-bit host handshake (init/load/fetch/idata/ack/odata) used to drive the SHABAL core.
- Assembles 16-bit host halfwords into 32-bit message words and buffers a 512-bit (16-word) block for the compression core.
- Serves the 256-bit digest back to the host as 16 halfwords.
- Sits between the host bus and the Shabal round engine.

Parameters:
- IOW, 16, host data width.
- WW, 32, message/digest word width.
- BLK_WORDS, 16, words per message block.
- DIG_HALVES, 16, halfwords per digest (256 bits).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- init  in  1  host: start new hash; clear counters.
- load  in  1  host: request to write idata.
- fetch  in  1  host: request to read next digest halfword.
- idata  in  16  host write data.
- ack  out  1  one-cycle pulse acknowledging one load or fetch.
- odata  out  16  host read data; valid from the ack cycle, held until the next fetch ack.
- core_init  out  1  one-cycle pulse to the core.
- blk_data  out  512  assembled block; word 0 in bits [31:0], first halfword = low half.
- blk_valid  out  1  block full, offered to core.
- blk_ready  in  1  core consumes block when blk_valid & blk_ready.
- dig_data  in  256  digest from core; halfword k = bits [16k+15:16k].
- dig_valid  in  1  digest stable and readable.

Behaviour:
- Reset: ack=0, odata=0, core_init=0, blk_valid=0, blk_data=0, half_cnt=0, word_cnt=0, rd_idx=0, state=IDLE.
- States:
  - IDLE: no load or fetch accepted until init.
  - FILL: accepting loads.
  - FULL: blk_valid=1, load stalled.
  - READ: serving fetches.
- init (any state) -> next cycle: core_init=1 for one cycle; counters cleared; blk_valid=0; state=FILL. init has priority over a simultaneous load or fetch; that load/fetch gets no ack.
- Accept rule: a request is accepted on a rising edge with request high, ack currently 0, and the state permitting it. ack=1 exactly one cycle later, for one cycle.
- A continuously held request therefore transfers at most once every 2 cycles. No ack without an accepted request.
- load accepted in FILL:
  - half_cnt=0: idata -> low half of word[word_cnt].
  - half_cnt=1: idata -> high half; word_cnt increments.
  - On the 32nd halfword (word_cnt wraps 15->0): state=FULL, blk_valid=1 in the same cycle as ack.
- FULL: load held with no ack, for any number of cycles. On blk_valid & blk_ready: blk_valid=0 next cycle, state=FILL; a stalled load is accepted on the following edge.
- fetch in FILL/FULL with dig_valid=1: state=READ, rd_idx=0. The first fetch is accepted on that edge.
- fetch while dig_valid=0: no ack; the host times out.
- fetch accepted in READ: odata<=dig_data[16*rd_idx +: 16] registered with ack; rd_idx increments mod 16, wrapping 15->0 so the digest can be re-read.
- load in READ: ignored, no ack.
- Simultaneous load and fetch: fetch wins in READ, load wins otherwise; the loser is not acked.
- dig_valid falling mid-READ: the current odata is kept; further fetches stall without ack until dig_valid=1.
- Async reset mid-transfer clears everything immediately. A partially assembled word is discarded.
- The core handles padding and final-block marking; this block passes halfwords verbatim.

Test Plan:
- Reset then init: rst high 3 cycles, init 1 cycle -> ack=0, odata=0000, exactly one core_init pulse, state FILL.
- Block fill: init, 32 loads idata=0x0000..0x001F with load held high -> 32 ack pulses 2 cycles apart; blk_valid rises with the 32nd ack; blk_data[31:0]=0x00010000, blk_data[511:480]=0x001F001E.
- Backpressure: blk_ready=0 for 10 cycles with load high and idata=0xAAAA -> no ack for 10 cycles. blk_ready=1 -> blk_valid drops; ack 2 cycles later; word0 low half=0xAAAA.
- Digest read: dig_data halfword k = 0x1000+k, dig_valid=1, 17 fetches -> odata 0x1000..0x100F then 0x1000 (wrap), one ack each.
- Stall/priority: fetch with dig_valid=0 for 20 cycles -> no ack. init and load asserted on the same edge -> core_init pulse, no ack, half_cnt=0.
- Reset mid-block: after 5 loads, assert rst -> blk_valid=0, counters 0. Next init plus 32 loads produce a fresh block with no stale data.

Source files
------------

// File: rtl/shabal_host_if.sv
// shabal_host_if: 16-bit host handshake responder for the Shabal core.
// Packs host halfwords into a 512-bit block and serves the 256-bit digest back as halfwords.
module shabal_host_if #(
    parameter int IOW        = 16,
    parameter int WW         = 32,
    parameter int BLK_WORDS  = 16,
    parameter int DIG_HALVES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init,
    input  logic                      load,
    input  logic                      fetch,
    input  logic [IOW-1:0]            idata,
    output logic                      ack,
    output logic [IOW-1:0]            odata,
    output logic                      core_init,
    output logic [WW*BLK_WORDS-1:0]   blk_data,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    input  logic [IOW*DIG_HALVES-1:0] dig_data,
    input  logic                      dig_valid
);
    localparam int WB = $clog2(BLK_WORDS);
    localparam int RB = $clog2(DIG_HALVES);
    typedef enum logic [1:0] {IDLE, FILL, FULL, READ} state_t;
    state_t                    state_q, state_d;
    logic                      ack_q, ack_d, core_init_q, core_init_d, blk_valid_q, blk_valid_d;
    logic                      half_q, half_d;
    logic [WB-1:0]             word_q, word_d;
    logic [RB-1:0]             rd_q, rd_d, rd_base;
    logic [IOW-1:0]            odata_q, odata_d;
    logic [WW*BLK_WORDS-1:0]   blk_q, blk_d;
    logic                      fetch_go, ld_acc;
    // Outside READ a concurrent load in FILL beats the fetch.
    assign fetch_go = fetch & dig_valid & (state_q != IDLE) & ~(load & (state_q == FILL));
    assign ld_acc   = load & ~ack_q & (state_q == FILL);
    assign rd_base  = (state_q == READ) ? rd_q : '0;
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        core_init_d = 1'b0;
        odata_d     = odata_q;
        blk_valid_d = blk_valid_q & ~blk_ready;
        half_d      = half_q;
        word_d      = word_q;
        rd_d        = rd_q;
        blk_d       = blk_q;
        if (init) begin
            state_d     = FILL;
            core_init_d = 1'b1;
            half_d      = 1'b0;
            word_d      = '0;
            rd_d        = '0;
            blk_valid_d = 1'b0;
        end else if (fetch_go) begin
            state_d = READ;
            rd_d    = rd_base;
            if (!ack_q) begin
                ack_d   = 1'b1;
                odata_d = dig_data[rd_base*IOW +: IOW];
                rd_d    = rd_base + 1'b1;
            end
        end else if (ld_acc) begin
            ack_d                         = 1'b1;
            blk_d[{word_q, half_q}*IOW +: IOW] = idata;
            half_d                        = ~half_q;
            word_d                        = half_q ? word_q + 1'b1 : word_q;
            state_d                       = (half_q && word_q == WB'(BLK_WORDS-1)) ? FULL : FILL;
            blk_valid_d                   = half_q && word_q == WB'(BLK_WORDS-1);
        end else if (state_q == FULL && blk_valid_q && blk_ready) begin
            state_d = FILL;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ack_q       <= 1'b0;
            core_init_q <= 1'b0;
            odata_q     <= '0;
            blk_valid_q <= 1'b0;
            half_q      <= 1'b0;
            word_q      <= '0;
            rd_q        <= '0;
            blk_q       <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            core_init_q <= core_init_d;
            odata_q     <= odata_d;
            blk_valid_q <= blk_valid_d;
            half_q      <= half_d;
            word_q      <= word_d;
            rd_q        <= rd_d;
            blk_q       <= blk_d;
        end
    end
    assign ack       = ack_q;
    assign odata     = odata_q;
    assign core_init = core_init_q;
    assign blk_valid = blk_valid_q;
    assign blk_data  = blk_q;
endmodule

// File: tb/tb_shabal_host_if.sv
// tb_shabal_host_if: directed checks of the host handshake, block assembly and digest readout.
module tb_shabal_host_if;
    logic         clk = 1'b0, rst = 1'b1;
    logic         init = 1'b0, load = 1'b0, fetch = 1'b0, blk_ready = 1'b0, dig_valid = 1'b0;
    logic [15:0]  idata = '0;
    logic         ack, core_init, blk_valid;
    logic [15:0]  odata;
    logic [511:0] blk_data;
    logic [255:0] dig_data;
    int           errors = 0, checks = 0;

    shabal_host_if dut (
        .clk(clk), .rst(rst), .init(init), .load(load), .fetch(fetch), .idata(idata),
        .ack(ack), .odata(odata), .core_init(core_init), .blk_data(blk_data),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .dig_data(dig_data), .dig_valid(dig_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic init, load, fetch, dv;
        logic exp_ack, exp_ci;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ack && n < 8);
    endtask

    task automatic fill_block(input logic [15:0] base);
        int n;
        init = 1'b1;
        step();
        init = 1'b0;
        chk("fill core_init", 32'(core_init), 1);
        chk("fill init ack", 32'(ack), 0);
        load = 1'b1;
        for (int i = 0; i < 32; i++) begin
            idata = base + 16'(i);
            wait_ack(n);
            chk($sformatf("fill gap %0d", i), n, (i == 0) ? 1 : 2);
            chk($sformatf("fill blk_valid %0d", i), 32'(blk_valid), (i == 31) ? 1 : 0);
        end
        load = 1'b0;
        for (int j = 0; j < 16; j++)
            chk($sformatf("fill word %0d", j), blk_data[32*j +: 32],
                {base + 16'(2*j+1), base + 16'(2*j)});
    endtask

    vec_t vt[13];
    int   n, acks;

    initial begin
        for (int k = 0; k < 16; k++) dig_data[16*k +: 16] = 16'h1000 + 16'(k);
        //          init load fetch dv  ack ci
        vt[0]  = '{0, 1, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 1, 1, 0, 0};
        vt[2]  = '{1, 1, 0, 0, 0, 1};
        vt[3]  = '{0, 1, 0, 0, 1, 0};
        vt[4]  = '{0, 1, 0, 0, 0, 0};
        vt[5]  = '{0, 0, 1, 0, 0, 0};
        vt[6]  = '{0, 0, 1, 0, 0, 0};
        vt[7]  = '{1, 0, 1, 1, 0, 1};
        vt[8]  = '{0, 0, 1, 1, 1, 0};
        vt[9]  = '{0, 1, 0, 1, 0, 0};
        vt[10] = '{0, 1, 0, 1, 0, 0};
        vt[11] = '{0, 1, 1, 1, 1, 0};
        vt[12] = '{0, 0, 0, 1, 0, 0};

        repeat (3) step();
        chk("rst ack", 32'(ack), 0);
        chk("rst odata", 32'(odata), 0);
        chk("rst core_init", 32'(core_init), 0);
        chk("rst blk_valid", 32'(blk_valid), 0);
        chk("rst blk_data", 32'(|blk_data), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 13; i++) begin
            init = vt[i].init; load = vt[i].load; fetch = vt[i].fetch; dig_valid = vt[i].dv;
            step();
            chk($sformatf("vec%0d ack", i), 32'(ack), 32'(vt[i].exp_ack));
            chk($sformatf("vec%0d core_init", i), 32'(core_init), 32'(vt[i].exp_ci));
        end
        init = 0; load = 0; fetch = 0; dig_valid = 0;
        step();

        fill_block(16'h0000);
        chk("blk word0", blk_data[31:0], 32'h00010000);
        chk("blk word15", blk_data[511:480], 32'h001F001E);

        load = 1'b1; idata = 16'hAAAA; blk_ready = 1'b0; acks = 0;
        repeat (10) begin step(); acks += int'(ack); end
        chk("bp stalled acks", acks, 0);
        chk("bp blk_valid held", 32'(blk_valid), 1);
        blk_ready = 1'b1;
        step();
        chk("bp blk_valid drop", 32'(blk_valid), 0);
        chk("bp ack early", 32'(ack), 0);
        step();
        chk("bp ack", 32'(ack), 1);
        load = 1'b0; blk_ready = 1'b0;
        chk("bp word0 low", 32'(blk_data[15:0]), 32'hAAAA);
        step();

        dig_valid = 1'b1; fetch = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wait_ack(n);
            chk($sformatf("dig gap %0d", i), n, (i == 0) ? 1 : 2);
            chk($sformatf("dig odata %0d", i), 32'(odata), 32'h1000 + 32'(i % 16));
        end
        fetch = 1'b0;
        step();

        dig_valid = 1'b0; fetch = 1'b1; acks = 0;
        repeat (20) begin step(); acks += int'(ack); end
        chk("stall acks", acks, 0);
        chk("stall odata kept", 32'(odata), 32'h1000);
        fetch = 1'b0; dig_valid = 1'b1;

        init = 1'b1; load = 1'b1; idata = 16'h5555;
        step();
        chk("prio core_init", 32'(core_init), 1);
        chk("prio ack", 32'(ack), 0);
        init = 1'b0;
        step();
        chk("prio core_init single", 32'(core_init), 0);
        chk("prio load ack", 32'(ack), 1);
        load = 1'b0;
        chk("prio half0", 32'(blk_data[15:0]), 32'h5555);
        step();

        init = 1'b1; step(); init = 1'b0;
        load = 1'b1; idata = 16'hBEEF;
        for (int i = 0; i < 5; i++) wait_ack(n);
        load = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid rst blk_valid", 32'(blk_valid), 0);
        chk("mid rst blk_data", 32'(|blk_data), 0);
        chk("mid rst ack", 32'(ack), 0);
        step();
        rst = 1'b0;
        step();
        fill_block(16'h0100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
